// File: rtl/lsu_sram_queue.sv
// Load/store unit bridging the MEM stage to an sram_like data bus.
// Up to DEPTH requests may be outstanding. Responses return in order, and
// load data is extracted and extended. Misaligned ops are answered locally
// without a bus access. A cancel drains in-flight responses and discards them.
module lsu_sram_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_W     = 5,
    parameter logic [31:0] ADDR_MASK = 32'h1FFFFFFF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cancel,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_store,
    output logic             resp_adel,
    output logic             resp_ades,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    input  logic [31:0]      data_rdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             wr;
        logic [1:0]       size;
        logic             uns;
        logic [1:0]       off;
    } entry_t;

    entry_t           queue [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;
    state_t           state_nxt;

    logic             misaligned_c;
    logic             exc_accept_c;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] count_nxt_c;
    entry_t           head_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [31:0]      load_data_c;

    // Handshake, bus drive and next-state decode
    always_comb begin
        misaligned_c = 1'b0;
        data_req     = 1'b0;
        push_c       = 1'b0;
        exc_accept_c = 1'b0;
        req_ready    = 1'b0;
        pop_c        = 1'b0;
        count_nxt_c  = count;
        state_nxt    = state;
        data_wr      = req_wr;
        data_size    = req_size;
        data_addr    = req_addr & ADDR_MASK;
        data_wdata   = req_wdata;

        misaligned_c = ((req_size == 2'd1) && req_addr[0]) ||
                       ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
        data_req     = req_valid && !misaligned_c && (state == ST_RUN) &&
                       (count < CNT_W'(DEPTH)) && !cancel;
        push_c       = data_req && data_addr_ok;
        // exceptions wait until the bus side is empty so responses stay ordered
        exc_accept_c = req_valid && misaligned_c && (state == ST_RUN) && (count == '0);
        req_ready    = push_c || exc_accept_c;
        pop_c        = data_data_ok && (count != '0);
        count_nxt_c  = count + CNT_W'(push_c) - CNT_W'(pop_c);

        case (req_size)
            2'd0:    data_wdata = {4{req_wdata[7:0]}};
            2'd1:    data_wdata = {2{req_wdata[15:0]}};
            default: data_wdata = req_wdata;
        endcase

        case (state)
            ST_RUN:   if (cancel && (count_nxt_c != '0)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (count_nxt_c == '0) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Extract and extend load data for the entry at the head of the queue
    always_comb begin
        head_c      = queue[rd_ptr];
        byte_c      = data_rdata[7:0];
        half_c      = data_rdata[15:0];
        load_data_c = data_rdata;

        case (head_c.off)
            2'd0:    byte_c = data_rdata[7:0];
            2'd1:    byte_c = data_rdata[15:8];
            2'd2:    byte_c = data_rdata[23:16];
            default: byte_c = data_rdata[31:24];
        endcase
        half_c = head_c.off[1] ? data_rdata[31:16] : data_rdata[15:0];

        case (head_c.size)
            2'd0:    load_data_c = {{24{~head_c.uns & byte_c[7]}}, byte_c};
            2'd1:    load_data_c = {{16{~head_c.uns & half_c[15]}}, half_c};
            default: load_data_c = data_rdata;
        endcase
        if (head_c.wr) load_data_c = '0;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_RUN;
        else         state <= state_nxt;
    end

    // Outstanding-request queue: pointers, count and per-entry metadata
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) queue[i] <= '0;
        end else begin
            if (push_c) begin
                queue[wr_ptr] <= '{tag: req_tag, wr: req_wr, size: req_size,
                                   uns: req_unsigned, off: req_addr[1:0]};
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt_c;
        end
    end

    // Registered response: bus completion or local exception; both killed by cancel
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_tag   <= '0;
            resp_store <= 1'b0;
            resp_adel  <= 1'b0;
            resp_ades  <= 1'b0;
        end else if (pop_c && (state == ST_RUN) && !cancel) begin
            resp_valid <= 1'b1;
            resp_rdata <= load_data_c;
            resp_tag   <= head_c.tag;
            resp_store <= head_c.wr;
            resp_adel  <= 1'b0;
            resp_ades  <= 1'b0;
        end else if (exc_accept_c && !cancel) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_tag   <= req_tag;
            resp_store <= req_wr;
            resp_adel  <= !req_wr;
            resp_ades  <= req_wr;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_tag   <= '0;
            resp_store <= 1'b0;
            resp_adel  <= 1'b0;
            resp_ades  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_sram_queue.sv
// Directed bench for lsu_sram_queue: table of single transactions plus
// hand-written sequences for queue full, misalignment and cancel/drain.
module tb_lsu_sram_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cancel;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_tag;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_tag;
    logic        resp_store;
    logic        resp_adel;
    logic        resp_ades;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    int errors = 0;
    int checks = 0;

    lsu_sram_queue #(.DEPTH(4), .TAG_W(5), .ADDR_MASK(32'h1FFFFFFF)) dut (
        .clk(clk), .resetn(resetn), .cancel(cancel),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_tag(resp_tag),
        .resp_store(resp_store), .resp_adel(resp_adel), .resp_ades(resp_ades),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  tag;
        logic [31:0] rdata;
        logic [31:0] exp_daddr;
        logic [31:0] exp_dwdata;
        logic [31:0] exp_resp;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic wr, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] tag);
        req_valid    = 1'b1;
        req_wr       = wr;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_tag      = tag;
    endtask

    // Complete one aligned load already accepted: data_ok now, check response
    task automatic finish_load(input logic [31:0] rdata, input logic [31:0] exp,
                               input logic [4:0] tag, input string name);
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        tick();
        data_data_ok = 1'b0;
        chk({name, " resp_valid"}, 32'(resp_valid), 32'd1);
        chk({name, " resp_rdata"}, resp_rdata, exp);
        chk({name, " resp_tag"}, 32'(resp_tag), 32'(tag));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        wr    size  uns   addr           wdata          tag    rdata          daddr          dwdata         resp
        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'hBFC00010, 32'h00000000, 5'd3,  32'h8899AABB, 32'h1FC00010, 32'h00000000, 32'h8899AABB};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h00001001, 32'h00000000, 5'd4,  32'h80FF7F01, 32'h00001001, 32'h00000000, 32'h0000007F};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h00001003, 32'h00000000, 5'd5,  32'h80FF7F01, 32'h00001003, 32'h00000000, 32'hFFFFFF80};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h00001001, 32'h00000000, 5'd6,  32'h80FF7F01, 32'h00001001, 32'h00000000, 32'h0000007F};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h00001003, 32'h00000000, 5'd7,  32'h80FF7F01, 32'h00001003, 32'h00000000, 32'h00000080};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h80000002, 32'h00001234, 5'd8,  32'hFFFFFFFF, 32'h00000002, 32'h12341234, 32'h00000000};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h00002002, 32'h00000000, 5'd9,  32'h80FF7F01, 32'h00002002, 32'h00000000, 32'hFFFF80FF};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h00002000, 32'h00000000, 5'd10, 32'h80FF7F01, 32'h00002000, 32'h00000000, 32'h00007F01};
        vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'hA0000003, 32'hDEADBEA5, 5'd11, 32'h00000000, 32'h00000003, 32'hA5A5A5A5, 32'h00000000};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'hCAFEF00D, 5'd12, 32'h00000000, 32'h1FFFFFFC, 32'hCAFEF00D, 32'h00000000};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 32'h00003002, 32'h00000000, 5'd13, 32'h80FF7F01, 32'h00003002, 32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h00003002, 32'h00000000, 5'd14, 32'h80FF7F01, 32'h00003002, 32'h00000000, 32'h000080FF};

        resetn = 1'b0; cancel = 1'b0; req_valid = 1'b0; req_wr = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        req_tag = '0; data_rdata = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        tick(); tick(); tick();
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_tag", 32'(resp_tag), 32'd0);
        chk("reset resp_adel", 32'(resp_adel), 32'd0);
        resetn = 1'b1;
        tick();

        // single-transaction table
        for (int i = 0; i < 12; i++) begin
            set_req(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, vecs[i].tag);
            data_addr_ok = 1'b1;
            #1;
            chk($sformatf("v%0d data_req", i), 32'(data_req), 32'd1);
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'd1);
            chk($sformatf("v%0d data_addr", i), data_addr, vecs[i].exp_daddr);
            chk($sformatf("v%0d data_wdata", i), data_wdata, vecs[i].exp_dwdata);
            chk($sformatf("v%0d data_size", i), 32'(data_size), 32'(vecs[i].size));
            chk($sformatf("v%0d data_wr", i), 32'(data_wr), 32'(vecs[i].wr));
            tick();
            req_valid = 1'b0; data_addr_ok = 1'b0;
            chk($sformatf("v%0d early resp_valid", i), 32'(resp_valid), 32'd0);
            tick();
            chk($sformatf("v%0d wait resp_valid", i), 32'(resp_valid), 32'd0);
            data_data_ok = 1'b1; data_rdata = vecs[i].rdata;
            tick();
            data_data_ok = 1'b0; data_rdata = '0;
            chk($sformatf("v%0d resp_valid", i), 32'(resp_valid), 32'd1);
            chk($sformatf("v%0d resp_rdata", i), resp_rdata, vecs[i].exp_resp);
            chk($sformatf("v%0d resp_tag", i), 32'(resp_tag), 32'(vecs[i].tag));
            chk($sformatf("v%0d resp_store", i), 32'(resp_store), 32'(vecs[i].wr));
            chk($sformatf("v%0d resp_adel", i), 32'(resp_adel), 32'd0);
        end
        tick();
        chk("table tail resp_valid", 32'(resp_valid), 32'd0);

        // four back-to-back loads fill the queue; fifth is refused
        data_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b0, 2'd2, 1'b0, 32'h00000100 + 32'(4 * i), 32'd0, 5'(16 + i));
            #1;
            chk($sformatf("b2b%0d req_ready", i), 32'(req_ready), 32'd1);
            tick();
        end
        set_req(1'b0, 2'd2, 1'b0, 32'h00000110, 32'd0, 5'd20);
        #1;
        chk("full req_ready", 32'(req_ready), 32'd0);
        chk("full data_req", 32'(data_req), 32'd0);
        tick();
        req_valid = 1'b0; data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_rdata = 32'h11110000 + 32'(i);
            tick();
            chk($sformatf("b2b%0d resp_valid", i), 32'(resp_valid), 32'd1);
            chk($sformatf("b2b%0d resp_rdata", i), resp_rdata, 32'h11110000 + 32'(i));
            chk($sformatf("b2b%0d resp_tag", i), 32'(resp_tag), 32'(16 + i));
        end
        data_data_ok = 1'b0;
        tick();
        chk("b2b tail resp_valid", 32'(resp_valid), 32'd0);

        // misaligned word load with empty queue: local adel, no bus access
        set_req(1'b0, 2'd2, 1'b0, 32'h00000106, 32'd0, 5'd21);
        data_addr_ok = 1'b1;
        #1;
        chk("adel data_req", 32'(data_req), 32'd0);
        chk("adel req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("adel resp_valid", 32'(resp_valid), 32'd1);
        chk("adel resp_adel", 32'(resp_adel), 32'd1);
        chk("adel resp_ades", 32'(resp_ades), 32'd0);
        chk("adel resp_rdata", resp_rdata, 32'd0);
        chk("adel resp_tag", 32'(resp_tag), 32'd21);
        tick();
        chk("adel pulse end", 32'(resp_valid), 32'd0);

        // misaligned halfword store: ades
        set_req(1'b1, 2'd1, 1'b0, 32'h00000201, 32'h0000BEEF, 5'd22);
        tick();
        req_valid = 1'b0;
        chk("ades resp_ades", 32'(resp_ades), 32'd1);
        chk("ades resp_adel", 32'(resp_adel), 32'd0);
        chk("ades resp_store", 32'(resp_store), 32'd1);

        // misaligned op waits while two loads are outstanding
        set_req(1'b0, 2'd2, 1'b0, 32'h00000300, 32'd0, 5'd1); tick();
        set_req(1'b0, 2'd2, 1'b0, 32'h00000304, 32'd0, 5'd2); tick();
        set_req(1'b0, 2'd2, 1'b0, 32'h00000306, 32'd0, 5'd23);
        #1;
        chk("mis cnt2 req_ready", 32'(req_ready), 32'd0);
        finish_load(32'hAAAA0001, 32'hAAAA0001, 5'd1, "mis pop1");
        chk("mis cnt1 req_ready", 32'(req_ready), 32'd0);
        finish_load(32'hAAAA0002, 32'hAAAA0002, 5'd2, "mis pop2");
        #1;
        chk("mis cnt0 req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("mis late resp_adel", 32'(resp_adel), 32'd1);
        chk("mis late resp_tag", 32'(resp_tag), 32'd23);
        tick();

        // cancel with three loads outstanding: drain silently, then resume
        for (int i = 0; i < 3; i++) begin
            set_req(1'b0, 2'd2, 1'b0, 32'h00000400 + 32'(4 * i), 32'd0, 5'(24 + i));
            tick();
        end
        req_valid = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        set_req(1'b0, 2'd2, 1'b0, 32'h00000500, 32'd0, 5'd27);
        #1;
        chk("drain data_req", 32'(data_req), 32'd0);
        chk("drain req_ready", 32'(req_ready), 32'd0);
        data_data_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_rdata = 32'hDEAD0000 + 32'(i);
            tick();
            chk($sformatf("drain%0d resp_valid", i), 32'(resp_valid), 32'd0);
            if (i < 2) chk($sformatf("drain%0d req_ready", i), 32'(req_ready), 32'd0);
        end
        data_data_ok = 1'b0;
        #1;
        chk("post-drain req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        tick();
        finish_load(32'h5A5A1234, 32'h5A5A1234, 5'd27, "post-drain");
        tick();

        // cancel alongside a misaligned op on an empty queue: no response, stay in RUN
        set_req(1'b0, 2'd2, 1'b0, 32'h00000602, 32'd0, 5'd28);
        cancel = 1'b1;
        tick();
        cancel = 1'b0; req_valid = 1'b0;
        chk("cancel exc resp_valid", 32'(resp_valid), 32'd0);
        chk("cancel exc resp_adel", 32'(resp_adel), 32'd0);
        set_req(1'b0, 2'd2, 1'b0, 32'h00000700, 32'd0, 5'd29);
        #1;
        chk("cancel exc still run", 32'(data_req), 32'd1);
        tick();
        req_valid = 1'b0;
        finish_load(32'h01234567, 32'h01234567, 5'd29, "after cancel exc");

        // stray data_ok on an empty queue is ignored
        tick();
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk("stray resp_valid", 32'(resp_valid), 32'd0);
        set_req(1'b0, 2'd0, 1'b1, 32'h00000802, 32'd0, 5'd30);
        #1;
        chk("stray count ok", 32'(data_req), 32'd1);
        tick();
        req_valid = 1'b0; data_addr_ok = 1'b0;
        finish_load(32'h00C30000, 32'h000000C3, 5'd30, "after stray");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_sram_queue.md
Name: lsu_sram_queue

Overview:
- Parametrised load/store unit between the MEM pipeline stage and the sram_like data bus.
- Accepts load/store operations through a valid/ready handshake and keeps up to DEPTH bus transactions outstanding: accepted by data_addr_ok, not yet answered by data_data_ok.
- Returns results in order with byte/halfword extraction and sign extension.
- Detects misalignment exceptions (adel/ades) locally, without a bus access.
- Supports pipeline cancel by draining in-flight responses and discarding them.

Parameters:
- DEPTH, 4, max outstanding bus transactions; power of 2, >=2
- TAG_W, 5, width of the pipeline tag carried with each request (e.g. wdest)
- ADDR_MASK, 32'h1FFFFFFF, mask applied to the virtual address to form data_addr

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- cancel  in  1  flush: kill all accepted, unanswered operations
- req_valid  in  1  operation presented
- req_ready  out  1  operation accepted this cycle when req_valid&req_ready
- req_wr  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word
- req_unsigned  in  1  zero-extend load result
- req_addr  in  32  virtual address
- req_wdata  in  32  store data, right-aligned
- req_tag  in  TAG_W  returned with the response
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data (0 for stores/exceptions)
- resp_tag  out  TAG_W  tag of the responding operation
- resp_store  out  1  response belongs to a store
- resp_adel  out  1  misaligned load
- resp_ades  out  1  misaligned store
- data_req  out  1  sram_like request
- data_wr  out  1  sram_like write
- data_size  out  2  sram_like size
- data_addr  out  32  req_addr & ADDR_MASK
- data_wdata  out  32  lane-replicated store data
- data_rdata  in  32  read data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response returned (in order)

Behaviour:
- Reset (resetn=0 at posedge):
  - count=0, rd/wr pointers=0, state=RUN.
  - resp_valid=0, resp_* = 0.
  - All entry metadata cleared.
- Misalignment:
  - Misaligned when size=1 & addr[0], or size=2 & addr[1:0]!=0.
  - A misaligned op is accepted only when state=RUN and count==0; no data_req is issued.
  - The registered response follows 1 cycle later with adel/ades=1 and rdata=0.
- Aligned ops:
  - data_req = req_valid & aligned & state==RUN & count<DEPTH & !cancel (combinational).
  - data_wr/data_size/data_addr pass through combinationally.
  - req_ready = data_req & data_addr_ok.
  - On acceptance, push {tag, wr, size, unsigned, addr[1:0]} at wr_ptr.
- Store lanes: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word -> wdata.
- Response to data_data_ok:
  - Pops the entry at rd_ptr.
  - Registered response next cycle: resp_valid=1, tag/store from the entry.
- Load extraction:
  - byte: selected by addr[1:0].
  - half: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
  - Sign-extended unless unsigned.
- Pointer and count rules:
  - Pointers wrap mod DEPTH.
  - Push and pop in the same cycle: count unchanged.
  - Full (count==DEPTH): data_req=0, req_ready=0.
  - data_data_ok with count==0 is a protocol error: ignored, count stays 0.
- FSM, RUN / DRAIN:
  - RUN -> DRAIN when cancel=1 and (count>0, or an accept is in the same cycle — none, because cancel gates data_req).
  - In DRAIN: no new ops accepted; each data_data_ok pops silently with resp_valid=0.
  - DRAIN -> RUN in the cycle the count reaches 0.
  - cancel with count==0 stays in RUN; any pending exception response registered that cycle is suppressed.
  - cancel asserted while already in DRAIN: no effect.
- Latency:
  - Aligned: response 1 cycle after data_data_ok.
  - Exception: response 1 cycle after acceptance.
- Throughput: 1 op/cycle when data_addr_ok is held high.

Test Plan:
- Word load at 0xBFC00010, addr_ok same cycle, data_ok 2 cycles later with rdata=0x8899AABB -> data_addr=0x1FC00010; resp_valid 1 cycle after data_ok, rdata=0x8899AABB, tag echoed.
- Byte loads at offsets 1 and 3 of rdata=0x80FF7F01, signed then unsigned -> 0x0000007F / 0xFFFFFF80 signed; 0x0000007F / 0x00000080 unsigned.
- Halfword store 0x1234 at addr 0x...2 -> data_size=1, data_wdata=0x12341234; resp_store=1 after data_ok.
- 4 back-to-back loads with addr_ok=1 and data_ok withheld -> count=4, 5th req_ready=0; 4 data_ok pulses -> 4 in-order responses; both pointers wrapped to 0.
- Word load at addr 0x...6 with count==0 -> no data_req; resp_adel=1 next cycle. Same op while count=2 -> req_ready=0 until count=0.
- 3 loads outstanding, cancel pulse -> state DRAIN, req_valid ignored; 3 data_ok produce no resp_valid; RUN after the 3rd; the next load completes normally.
